// File: rtl/decoder_bus_responder_if.sv
// Register-side bus between the PIO link responder and the local decoder registers.
// The responder is the master; the register file is the slave and returns read data.
interface decoder_bus_responder_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/decoder_bus_responder.sv
// Far-end responder for the toggle-marked 8-bit PIO link: assembles address/data nibbles,
// strobes local registers and returns read data on the shared bus after a turnaround window.
module decoder_bus_responder #(
  parameter int unsigned TURN_CYCLES  = 16,
  parameter int unsigned DRIVE_CYCLES = 64,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  inout  wire  [7:0]                     bidir_port_io,
  decoder_bus_responder_if.master        reg_if,
  output logic                           proto_err_o,
  output logic                           busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StDecode,
    StRcap,
    StTurn,
    StDrive,
    StGuard
  } state_e;

  localparam logic [2:0] CodeAddrLo = 3'd0;
  localparam logic [2:0] CodeAddrHi = 3'd1;
  localparam logic [2:0] CodeDataLo = 3'd2;
  localparam logic [2:0] CodeDataHi = 3'd3;
  localparam logic [2:0] CodeRead   = 3'd4;
  localparam logic [2:0] CodeAbort  = 3'd5;

  // The RCAP cycle is part of the turnaround count, so oe rises TURN_CYCLES after rd_buf loads.
  localparam logic [15:0] TurnLoad  = 16'(TURN_CYCLES - 1);
  localparam logic [15:0] DriveLoad = 16'(DRIVE_CYCLES - 1);
  localparam logic [15:0] GuardLoad = 16'(GUARD_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  s1_q, s2_q;
  logic        tog_last_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        lo_valid_q;
  logic        proto_err_q;
  logic        reg_we_q;
  logic        reg_re_q;
  logic [7:0]  rd_buf_q;
  logic        oe_q;
  logic        busy_q;
  logic [15:0] cnt_q;

  logic [2:0]  code;
  logic [3:0]  nib;

  assign code = s2_q[6:4];
  assign nib  = s2_q[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 8'h00;
      s2_q <= 8'h00;
    end else begin
      s1_q <= bidir_port_io;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tog_last_q  <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      lo_valid_q  <= 1'b0;
      proto_err_q <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rd_buf_q    <= 8'h00;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= 16'h0000;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s2_q[7] != tog_last_q) begin
            state_q <= StSettle;
            busy_q  <= 1'b1;
          end
        end

        StSettle: begin
          tog_last_q <= s2_q[7];
          state_q    <= StDecode;
          case (code)
            CodeAddrLo: addr_q[3:0] <= nib;
            CodeAddrHi: addr_q[7:4] <= nib;
            CodeDataLo: begin
              wdata_q[3:0] <= nib;
              lo_valid_q   <= 1'b1;
            end
            CodeDataHi: begin
              if (lo_valid_q) begin
                wdata_q[7:4] <= nib;
                reg_we_q     <= 1'b1;
                lo_valid_q   <= 1'b0;
              end else begin
                proto_err_q <= 1'b1;
              end
            end
            CodeRead:   reg_re_q <= 1'b1;
            CodeAbort: begin
              lo_valid_q  <= 1'b0;
              wdata_q     <= 8'h00;
              proto_err_q <= 1'b0;
            end
            default:    proto_err_q <= 1'b1;
          endcase
        end

        // Strobe cycle: the strobe flags still hold what SETTLE decided.
        StDecode: begin
          if (reg_we_q) begin
            addr_q <= addr_q + 8'd1;
          end
          if (reg_re_q) begin
            rd_buf_q <= reg_if.reg_rdata;
            cnt_q    <= TurnLoad;
            state_q  <= StRcap;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        StRcap: begin
          addr_q  <= addr_q + 8'd1;
          cnt_q   <= cnt_q - 16'd1;
          state_q <= StTurn;
        end

        StTurn: begin
          if (cnt_q == 16'd0) begin
            oe_q    <= 1'b1;
            cnt_q   <= DriveLoad;
            state_q <= StDrive;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        StDrive: begin
          if (cnt_q == 16'd0) begin
            oe_q    <= 1'b0;
            cnt_q   <= GuardLoad;
            state_q <= StGuard;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        StGuard: begin
          if (cnt_q == 16'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bidir_port_io    = oe_q ? rd_buf_q : 8'bzzzz_zzzz;
  assign reg_if.reg_addr  = addr_q;
  assign reg_if.reg_wdata = wdata_q;
  assign reg_if.reg_we    = reg_we_q;
  assign reg_if.reg_re    = reg_re_q;
  assign proto_err_o      = proto_err_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_decoder_bus_responder.sv
// Directed and randomized bench for decoder_bus_responder; a transaction-level model of
// the register/link rules supplies every expected value.
module tb_decoder_bus_responder;
  localparam int TURN  = 16;
  localparam int DRIVE = 64;
  localparam int GUARD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       host_oe = 1'b1;
  logic [7:0] host_val = 8'h00;
  logic       host_t = 1'b0;
  logic [7:0] rdata_tb = 8'h00;
  logic       proto_err_o;
  logic       busy_o;
  wire  [7:0] bus;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  bit         m_lo = 1'b0;
  bit         m_err = 1'b0;

  decoder_bus_responder_if rif ();

  assign bus           = host_oe ? host_val : 8'bzzzz_zzzz;
  assign rif.reg_rdata = rdata_tb;

  decoder_bus_responder #(
    .TURN_CYCLES (TURN),
    .DRIVE_CYCLES(DRIVE),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bidir_port_io(bus),
    .reg_if       (rif),
    .proto_err_o  (proto_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr  = 8'h00;
    m_wdata = 8'h00;
    m_lo    = 1'b0;
    m_err   = 1'b0;
  endtask

  // One host transfer; rst_mid pulls reset while the read byte is being driven.
  task automatic xfer(input logic [2:0] code, input logic [3:0] nib, input bit rst_mid);
    bit         e_we = 1'b0;
    bit         e_re = 1'b0;
    logic [7:0] e_addr = 8'h00;
    logic [7:0] e_data = 8'h00;
    int         we_n = 0, re_n = 0, we_c = 0, re_c = 0;
    int         oe_first = 0, oe_n = 0, bus_bad = 0, busy_low = 0;
    logic [7:0] g_waddr = 8'h00, g_wdata = 8'h00, g_raddr = 8'h00;
    bit         oe_prev = 1'b0;
    int         limit;

    case (code)
      3'd0: m_addr = (m_addr & 8'hF0) | {4'h0, nib};
      3'd1: m_addr = (m_addr & 8'h0F) | {nib, 4'h0};
      3'd2: begin
        m_wdata = (m_wdata & 8'hF0) | {4'h0, nib};
        m_lo    = 1'b1;
      end
      3'd3: begin
        if (m_lo) begin
          m_wdata = (m_wdata & 8'h0F) | {nib, 4'h0};
          e_we    = 1'b1;
          e_addr  = m_addr;
          e_data  = m_wdata;
          m_addr  = m_addr + 8'd1;
          m_lo    = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      3'd4: begin
        e_re   = 1'b1;
        e_addr = m_addr;
        e_data = rdata_tb;
        m_addr = m_addr + 8'd1;
      end
      3'd5: begin
        m_lo    = 1'b0;
        m_wdata = 8'h00;
        m_err   = 1'b0;
      end
      default: m_err = 1'b1;
    endcase

    @(negedge clk);
    host_t   = ~host_t;
    host_val = {host_t, code, nib};
    host_oe  = 1'b1;
    limit    = e_re ? 150 : 8;

    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (rif.reg_we) begin
        we_n++;
        we_c    = c;
        g_waddr = rif.reg_addr;
        g_wdata = rif.reg_wdata;
      end
      if (rif.reg_re) begin
        re_n++;
        re_c    = c;
        g_raddr = rif.reg_addr;
      end
      if (e_re) begin
        if (c == 6) host_oe = 1'b0;
        if (dut.oe_q) begin
          if (oe_first == 0) oe_first = c;
          oe_n++;
          if (bus !== e_data) bus_bad++;
          if (rst_mid && oe_n == 30) break;
        end else if (oe_prev) begin
          host_oe = 1'b1;  // re-drive the last byte, same T
        end
        oe_prev = dut.oe_q;
        if (c > 4 && !busy_o && busy_low == 0) begin
          busy_low = c;
          break;
        end
      end
    end

    if (rst_mid) begin
      #2 reset_n = 1'b0;
      #1;
      check("rst_oe", {31'd0, dut.oe_q}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_addr", {24'd0, rif.reg_addr}, 32'd0);
      check("rst_err", {31'd0, proto_err_o}, 32'd0);
      model_reset();
      host_t = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end else begin
      check("we_count", we_n, {31'd0, e_we});
      check("re_count", re_n, {31'd0, e_re});
      if (e_we) begin
        check("we_latency", we_c, 32'd4);
        check("we_addr", {24'd0, g_waddr}, {24'd0, e_addr});
        check("we_data", {24'd0, g_wdata}, {24'd0, e_data});
      end
      if (e_re) begin
        check("re_latency", re_c, 32'd4);
        check("re_addr", {24'd0, g_raddr}, {24'd0, e_addr});
        check("oe_rise", oe_first, TURN + 5);
        check("oe_width", oe_n, DRIVE);
        check("bus_data", bus_bad, 32'd0);
        check("busy_fall", busy_low, TURN + DRIVE + GUARD + 5);
      end
      check("addr_after", {24'd0, rif.reg_addr}, {24'd0, m_addr});
      check("proto_err", {31'd0, proto_err_o}, {31'd0, m_err});
      check("busy_idle", {31'd0, busy_o}, 32'd0);
    end
  endtask

  // New byte with the same T: must be ignored entirely.
  task automatic same_t();
    int strobes = 0;
    @(negedge clk);
    host_val = {host_t, 3'd0, ~host_val[3:0]};
    host_oe  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rif.reg_we || rif.reg_re || busy_o) strobes++;
    end
    check("same_t_activity", strobes, 32'd0);
    check("same_t_addr", {24'd0, rif.reg_addr}, {24'd0, m_addr});
  endtask

  initial begin
    logic [2:0] rc;

    repeat (3) @(negedge clk);
    check("reset_addr", {24'd0, rif.reg_addr}, 32'd0);
    check("reset_we", {31'd0, rif.reg_we}, 32'd0);
    check("reset_re", {31'd0, rif.reg_re}, 32'd0);
    check("reset_err", {31'd0, proto_err_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_oe", {31'd0, dut.oe_q}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Assembled write to 0xA5 = 0x3C
    xfer(3'd0, 4'h5, 1'b0);
    xfer(3'd1, 4'hA, 1'b0);
    xfer(3'd2, 4'hC, 1'b0);
    xfer(3'd3, 4'h3, 1'b0);

    // Burst across the address wrap
    xfer(3'd0, 4'hF, 1'b0);
    xfer(3'd1, 4'hF, 1'b0);
    xfer(3'd2, 4'h1, 1'b0);
    xfer(3'd3, 4'h2, 1'b0);
    xfer(3'd2, 4'h3, 1'b0);
    xfer(3'd3, 4'h4, 1'b0);

    // Read from 0x10
    xfer(3'd0, 4'h0, 1'b0);
    xfer(3'd1, 4'h1, 1'b0);
    rdata_tb = 8'h5A;
    xfer(3'd4, 4'h0, 1'b0);

    // Protocol errors and abort
    xfer(3'd5, 4'h0, 1'b0);
    xfer(3'd3, 4'h7, 1'b0);
    xfer(3'd5, 4'h0, 1'b0);
    xfer(3'd7, 4'h0, 1'b0);
    xfer(3'd5, 4'h0, 1'b0);
    xfer(3'd6, 4'h2, 1'b0);

    same_t();

    // Reset while driving read data, then resume
    xfer(3'd0, 4'h3, 1'b0);
    xfer(3'd1, 4'h2, 1'b0);
    rdata_tb = 8'hC3;
    xfer(3'd4, 4'h0, 1'b1);
    xfer(3'd0, 4'h9, 1'b0);
    xfer(3'd2, 4'h1, 1'b0);
    xfer(3'd3, 4'hE, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 7));
      if (rc == 3'd4 && $urandom_range(0, 2) != 0) rc = 3'd2;
      rdata_tb = 8'($urandom_range(0, 255));
      xfer(rc, 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
